// File: rtl/ps2_mouse_init_seq_if.sv
// ps2_mouse_init_seq_if
//   Byte-level link between the PS/2 mouse init sequencer and the PS/2
//   transmitter/receiver pair.
//   tx_valid/tx_data : command byte offered to the transmitter
//   tx_ready         : transmitter accepts the byte (tx_valid & tx_ready)
//   tx_done/tx_err   : one-cycle pulses, byte sent / transmit failed
//   rx_valid/rx_data : one-cycle pulse with a byte received from the mouse
//   master = sequencer side, slave = transmitter/receiver side.
interface ps2_mouse_init_seq_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       rx_valid;
    logic [7:0] rx_data;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, tx_done, tx_err, rx_valid, rx_data
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, tx_done, tx_err, rx_valid, rx_data
    );
endinterface

// File: rtl/ps2_mouse_init_seq.sv
// ps2_mouse_init_seq
//   Host-side bring-up sequencer for a PS/2 mouse: FF (reset) + BAT check
//   (AA, 00), F3 + sample rate, F4, each command ACKed with FA. Handles FE
//   resend requests, timeouts, transmit errors and bounded full restarts.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   restart_i         : one-cycle pulse, restart from RST_TX, clears err/retries
//   bus               : transmitter/receiver byte link (master side)
//   stream_en_o       : configured, downstream packet capture enabled
//   err_o             : sequence gave up
//   retry_cnt_o       : full restarts since reset/restart
//   state_dbg_o       : current state encoding
module ps2_mouse_init_seq #(
    parameter logic [7:0]  SAMPLE_RATE = 8'd100,
    parameter int unsigned ACK_TIMEOUT = 1_250_000,
    parameter int unsigned BAT_TIMEOUT = 40_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        restart_i,
    ps2_mouse_init_seq_if.master        bus,
    output logic                        stream_en_o,
    output logic                        err_o,
    output logic [1:0]                  retry_cnt_o,
    output logic [3:0]                  state_dbg_o
);
    localparam int unsigned TMAX = (BAT_TIMEOUT > ACK_TIMEOUT) ? BAT_TIMEOUT : ACK_TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] BAT_LAST = TW'(BAT_TIMEOUT - 1);

    typedef enum logic [3:0] {
        RST_TX   = 4'd0,  RST_ACK  = 4'd1,
        BAT_AA   = 4'd2,  BAT_ID   = 4'd3,
        SR_TX    = 4'd4,  SR_ACK   = 4'd5,
        RATE_TX  = 4'd6,  RATE_ACK = 4'd7,
        EN_TX    = 4'd8,  EN_ACK   = 4'd9,
        RUN      = 4'd10, ERROR    = 4'd11
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      resend_q, resend_d;
    logic [1:0]      retry_q, retry_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            sent_q, sent_d;     // byte handed to transmitter, awaiting tx_done
    logic            hp_q, hp_d;         // AA seen while in RUN (possible hot-plug)
    logic            stream_en_q, stream_en_d;
    logic            err_q, err_d;

    // Per-command lookup shared by a *_TX state and its *_ACK state.
    logic [7:0]      cmd_byte;
    state_e          ack_st, tx_st, next_st;
    logic            fail;

    always_comb begin
        cmd_byte = 8'hFF;
        ack_st   = RST_ACK;
        tx_st    = RST_TX;
        next_st  = BAT_AA;
        case (state_q)
            SR_TX, SR_ACK: begin
                cmd_byte = 8'hF3; ack_st = SR_ACK; tx_st = SR_TX; next_st = RATE_TX;
            end
            RATE_TX, RATE_ACK: begin
                cmd_byte = SAMPLE_RATE; ack_st = RATE_ACK; tx_st = RATE_TX; next_st = EN_TX;
            end
            EN_TX, EN_ACK: begin
                cmd_byte = 8'hF4; ack_st = EN_ACK; tx_st = EN_TX; next_st = RUN;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = '0;
        resend_d   = resend_q;
        retry_d    = retry_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        sent_d     = sent_q;
        hp_d       = hp_q;
        fail       = 1'b0;

        case (state_q)
            RST_TX, SR_TX, RATE_TX, EN_TX: begin
                if (bus.tx_err) begin
                    fail = 1'b1;
                end else if (bus.tx_done) begin
                    state_d    = ack_st;
                    sent_d     = 1'b0;
                    tx_valid_d = 1'b0;
                end else if (tx_valid_q) begin
                    if (bus.tx_ready) begin
                        tx_valid_d = 1'b0;
                        sent_d     = 1'b1;
                    end
                end else if (!sent_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = cmd_byte;
                end
            end
            RST_ACK, SR_ACK, RATE_ACK, EN_ACK: begin
                timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
                if (bus.rx_valid) begin
                    if (bus.rx_data == 8'hFA) begin
                        state_d  = next_st;
                        resend_d = '0;
                        timer_d  = '0;
                    end else if (bus.rx_data == 8'hFE && resend_q < 2'd2) begin
                        state_d  = tx_st;
                        resend_d = resend_q + 2'd1;
                        timer_d  = '0;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (timer_q == ACK_LAST) begin
                    fail = 1'b1;
                end
            end
            BAT_AA, BAT_ID: begin
                timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
                if (bus.rx_valid) begin
                    if (state_q == BAT_AA && bus.rx_data == 8'hAA) begin
                        state_d = BAT_ID;
                        timer_d = '0;
                    end else if (state_q == BAT_ID && bus.rx_data == 8'h00) begin
                        state_d  = SR_TX;
                        resend_d = '0;
                        timer_d  = '0;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (timer_q == BAT_LAST) begin
                    fail = 1'b1;
                end
            end
            RUN: begin
                // Mouse announces its own reset with AA then 00; re-run setup
                // without FF and without charging a retry.
                if (bus.rx_valid) begin
                    if (hp_q && bus.rx_data == 8'h00) begin
                        state_d  = SR_TX;
                        resend_d = '0;
                    end else begin
                        hp_d = (bus.rx_data == 8'hAA);
                    end
                end
            end
            default: ;
        endcase

        if (fail) begin
            resend_d   = '0;
            tx_valid_d = 1'b0;
            sent_d     = 1'b0;
            timer_d    = '0;
            if (32'(retry_q) < MAX_RETRY) begin
                retry_d = retry_q + 2'd1;
                state_d = RST_TX;
            end else begin
                state_d = ERROR;
            end
        end

        if (restart_i) begin
            state_d    = RST_TX;
            retry_d    = '0;
            resend_d   = '0;
            tx_valid_d = 1'b0;
            sent_d     = 1'b0;
            timer_d    = '0;
        end

        if (state_d != RUN) hp_d = 1'b0;
        stream_en_d = (state_d == RUN);
        err_d       = (state_d == ERROR);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RST_TX;
            timer_q     <= '0;
            resend_q    <= '0;
            retry_q     <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            sent_q      <= 1'b0;
            hp_q        <= 1'b0;
            stream_en_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            resend_q    <= resend_d;
            retry_q     <= retry_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            sent_q      <= sent_d;
            hp_q        <= hp_d;
            stream_en_q <= stream_en_d;
            err_q       <= err_d;
        end
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign stream_en_o  = stream_en_q;
    assign err_o        = err_q;
    assign retry_cnt_o  = retry_q;
    assign state_dbg_o  = state_q;
endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// tb_ps2_mouse_init_seq
//   Self-checking bench for ps2_mouse_init_seq: a table of scripted mouse
//   behaviours, hand-written timing/hot-plug/async-reset sequences, and
//   randomized episodes checked against a command-level reference model.
module tb_ps2_mouse_init_seq;
    localparam int unsigned ACK_T = 100;
    localparam int unsigned BAT_T = 300;
    localparam int unsigned MAXR  = 3;

    // Mouse reaction to one transmitted command byte.
    localparam int K_OK  = 0;  // FA (plus AA, 00 after FF)
    localparam int K_FE  = 1;  // FE resend request
    localparam int K_BAD = 2;  // 00 instead of FA
    localparam int K_SIL = 3;  // no reply at all
    localparam int K_TXE = 4;  // transmitter reports tx_err

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       restart = 1'b0;
    logic       stream_en, err;
    logic [1:0] retry_cnt;
    logic [3:0] state_dbg;

    ps2_mouse_init_seq_if bus();

    ps2_mouse_init_seq #(
        .SAMPLE_RATE (8'h64),
        .ACK_TIMEOUT (ACK_T),
        .BAT_TIMEOUT (BAT_T),
        .MAX_RETRY   (MAXR)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .restart_i   (restart),
        .bus         (bus),
        .stream_en_o (stream_en),
        .err_o       (err),
        .retry_cnt_o (retry_cnt),
        .state_dbg_o (state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int         kinds_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        string        name;
        int           nk;
        logic [63:0]  kinds;   // nibble i = reaction to transmission i
        logic [127:0] bytes;   // byte i = expected transmission i
        int           st;
        logic         se;
        logic         er;
        logic [1:0]   rc;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rx(input logic [7:0] b);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h5A;
    endtask

    task automatic xfer(input logic [7:0] exp, input bit use_err);
        int n = 0;
        while (bus.tx_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (bus.tx_valid !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL tx_wait: no tx_valid within 2000 cycles, expected byte %0h", exp);
            return;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chk("tx_data", bus.tx_data, exp);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        chk("tx_valid_drop", bus.tx_valid, 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (use_err) bus.tx_err = 1'b1;
        else         bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_err  = 1'b0;
        bus.tx_done = 1'b0;
    endtask

    task automatic respond(input int k, input logic [7:0] sent);
        case (k)
            K_OK: begin
                rx(8'hFA);
                if (sent == 8'hFF) begin
                    rx(8'hAA);
                    rx(8'h00);
                end
            end
            K_FE:    rx(8'hFE);
            K_BAD:   rx(8'h00);
            default: ;
        endcase
    endtask

    task automatic run_script();
        for (int i = 0; i < kinds_q.size(); i++) begin
            xfer(exp_q[i], kinds_q[i] == K_TXE);
            respond(kinds_q[i], exp_q[i]);
        end
    endtask

    task automatic check_final(input string nm, input int st, input logic se,
                               input logic er, input logic [1:0] rc);
        repeat (ACK_T + 30) @(negedge clk);
        chk({nm, "_state"}, state_dbg, st);
        chk({nm, "_stream_en"}, stream_en, se);
        chk({nm, "_err"}, err, er);
        chk({nm, "_retry"}, retry_cnt, rc);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_state", state_dbg, 0);
        chk("restart_err", err, 0);
        chk("restart_retry", retry_cnt, 0);
        chk("restart_stream_en", stream_en, 0);
        chk("restart_tx_valid", bus.tx_valid, 0);
    endtask

    task automatic load_ok(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        kinds_q = '{K_OK, K_OK, K_OK};
        exp_q   = '{b0, b1, b2};
    endtask

    // Command-level model: walk the command list, counting resends and
    // restarts, until the mouse is configured or the sequencer gives up.
    task automatic gen_random(output int st, output int rc);
        logic [7:0] cmds[4];
        int cmd, rs, rt, r, k;
        bit done;
        cmds = '{8'hFF, 8'hF3, 8'h64, 8'hF4};
        cmd = 0; rs = 0; rt = 0; done = 1'b0;
        kinds_q.delete();
        exp_q.delete();
        while (!done) begin
            r = $urandom_range(0, 99);
            k = (r < 60) ? K_OK : (r < 75) ? K_FE : (r < 85) ? K_BAD : (r < 90) ? K_SIL : K_TXE;
            exp_q.push_back(cmds[cmd]);
            kinds_q.push_back(k);
            if (k == K_OK) begin
                rs = 0;
                cmd++;
                if (cmd == 4) done = 1'b1;
            end else if (k == K_FE && rs < 2) begin
                rs++;
            end else begin
                rs = 0;
                cmd = 0;
                if (rt < int'(MAXR)) rt++;
                else done = 1'b1;
            end
        end
        st = (cmd == 4) ? 10 : 11;
        rc = rt;
    endtask

    initial begin
        int st, rc, n;

        tbl[0] = '{"happy",    4, 64'h0,         128'hF4_64_F3_FF,                   10, 1'b1, 1'b0, 2'd0};
        tbl[1] = '{"fe_f3",    5, 64'h00010,     128'hF4_64_F3_F3_FF,                10, 1'b1, 1'b0, 2'd0};
        tbl[2] = '{"exhaust",  4, 64'h2222,      128'hFF_FF_FF_FF,                   11, 1'b0, 1'b1, 2'd3};
        tbl[3] = '{"fe3_ff",   7, 64'h0000111,   128'hF4_64_F3_FF_FF_FF_FF,          10, 1'b1, 1'b0, 2'd1};
        tbl[4] = '{"txerr_f4", 8, 64'h00004000,  128'hF4_64_F3_FF_F4_64_F3_FF,       10, 1'b1, 1'b0, 2'd1};
        tbl[5] = '{"sil_rate", 7, 64'h0000300,   128'hF4_64_F3_FF_64_F3_FF,          10, 1'b1, 1'b0, 2'd1};

        bus.tx_ready = 1'b0;
        bus.tx_done  = 1'b0;
        bus.tx_err   = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        #2 rst = 1'b1;
        #2;
        chk("rst_state", state_dbg, 0);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_stream_en", stream_en, 0);
        chk("rst_err", err, 0);
        chk("rst_retry", retry_cnt, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Table-driven scripted episodes.
        foreach (tbl[v]) begin
            logic [63:0]  kk;
            logic [127:0] bb;
            do_restart();
            kk = tbl[v].kinds;
            bb = tbl[v].bytes;
            kinds_q.delete();
            exp_q.delete();
            for (int i = 0; i < tbl[v].nk; i++) begin
                kinds_q.push_back(int'(kk[4*i +: 4]));
                exp_q.push_back(bb[8*i +: 8]);
            end
            run_script();
            check_final(tbl[v].name, tbl[v].st, tbl[v].se, tbl[v].er, tbl[v].rc);
        end

        // ACK timeout: F4 unanswered, restart lands exactly ACK_T cycles after tx_done.
        do_restart();
        load_ok(8'hFF, 8'hF3, 8'h64);
        run_script();
        xfer(8'hF4, 1'b0);
        repeat (ACK_T - 1) @(negedge clk);
        chk("tmo_state_before", state_dbg, 9);
        @(negedge clk);
        chk("tmo_state_after", state_dbg, 0);
        chk("tmo_retry", retry_cnt, 1);
        xfer(8'hFF, 1'b0);

        // Hot-plug in RUN: AA, 00 re-runs setup from F3 without a retry.
        do_restart();
        kinds_q = '{K_OK, K_OK, K_OK, K_OK};
        exp_q   = '{8'hFF, 8'hF3, 8'h64, 8'hF4};
        run_script();
        repeat (3) @(negedge clk);
        chk("hp_run_state", state_dbg, 10);
        chk("hp_run_stream_en", stream_en, 1);
        rx(8'hAA);
        chk("hp_after_aa_stream_en", stream_en, 1);
        rx(8'h00);
        chk("hp_after_00_stream_en", stream_en, 0);
        chk("hp_after_00_state", state_dbg, 4);
        load_ok(8'hF3, 8'h64, 8'hF4);
        run_script();
        check_final("hotplug", 10, 1'b1, 1'b0, 2'd0);

        // Asynchronous reset while F4 is pending.
        do_restart();
        load_ok(8'hFF, 8'hF3, 8'h64);
        run_script();
        n = 0;
        while (bus.tx_valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("arst_pre_state", state_dbg, 8);
        chk("arst_pre_tx_valid", bus.tx_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_state", state_dbg, 0);
        chk("arst_tx_valid", bus.tx_valid, 0);
        chk("arst_tx_data", bus.tx_data, 0);
        chk("arst_stream_en", stream_en, 0);
        chk("arst_err", err, 0);
        chk("arst_retry", retry_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        xfer(8'hFF, 1'b0);

        // Randomized episodes against the command-level model.
        for (int e = 0; e < 16; e++) begin
            do_restart();
            gen_random(st, rc);
            run_script();
            check_final("rand", st, st == 10, st == 11, 2'(rc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
